alu_au_decoder: RTL and testbench



---
 rtl/alu_au_decoder.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_alu_au_decoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_au_decoder.sv
// RV32I decode / ALU / address-unit slice: three independent one-cycle registered units.
// Optional macro ALU_AU_DECODER_ILLEGAL_FLAG_EN enables the registered 'illegal' flag.
module alu_au_decoder #(
  parameter int OP_W  = 6,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  output logic [OP_W-1:0]   op,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic [31:0]       imm,
  output logic              has_imm,
  output logic              illegal,
  input  logic [31:0]       alu_value_1,
  input  logic [31:0]       alu_value_2,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [TAG_W-1:0]  alu_des_input,
  input  logic              alu_is_branch_input,
  output logic [31:0]       alu_result,
  output logic [TAG_W-1:0]  alu_des_rob,
  output logic [TAG_W-1:0]  alu_des_rs,
  output logic              alu_is_branch_out,
  output logic              alu_valid,
  input  logic [31:0]       au_value1,
  input  logic [31:0]       au_imm,
  input  logic [OP_W-1:0]   au_op,
  input  logic [TAG_W-1:0]  au_rob_number_input,
  input  logic [31:0]       au_ls_value,
  output logic [31:0]       au_addr,
  output logic [31:0]       au_ls_value_output,
  output logic [TAG_W-1:0]  au_rob_number,
  output logic [OP_W-1:0]   au_op_out,
  output logic              au_valid
);

  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(1),  OP_AUIPC = OP_W'(2),  OP_JAL  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(4),  OP_BEQ   = OP_W'(5),  OP_BNE  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(7),  OP_BGE   = OP_W'(8),  OP_BLTU = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU = OP_W'(10), OP_LB    = OP_W'(11), OP_LH   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(13), OP_LBU   = OP_W'(14), OP_LHU  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SB   = OP_W'(16), OP_SH    = OP_W'(17), OP_SW   = OP_W'(18);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(19), OP_SLTI  = OP_W'(20), OP_SLTIU = OP_W'(21);
  localparam logic [OP_W-1:0] OP_XORI = OP_W'(22), OP_ORI   = OP_W'(23), OP_ANDI = OP_W'(24);
  localparam logic [OP_W-1:0] OP_SLLI = OP_W'(25), OP_SRLI  = OP_W'(26), OP_SRAI = OP_W'(27);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(28), OP_SUB   = OP_W'(29), OP_SLL  = OP_W'(30);
  localparam logic [OP_W-1:0] OP_SLT  = OP_W'(31), OP_SLTU  = OP_W'(32), OP_XOR  = OP_W'(33);
  localparam logic [OP_W-1:0] OP_SRL  = OP_W'(34), OP_SRA   = OP_W'(35), OP_OR   = OP_W'(36);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(37);

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BR   = 7'b1100011, OPC_LD   = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP   = 7'b0110011;

  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction
  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction
  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction
  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opc = instruction[6:0];
  assign f3  = instruction[14:12];
  assign f7  = instruction[31:25];

  logic [OP_W-1:0] op_d, op_q;
  logic [4:0]      rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
  logic [31:0]     imm_d, imm_q;
  logic            has_imm_d, has_imm_q;

  // Decode: select the micro-op first, then extract only the fields that op uses.
  always_comb begin
    op_d = '0;
    case (opc)
      OPC_LUI:   op_d = OP_LUI;
      OPC_AUIPC: op_d = OP_AUIPC;
      OPC_JAL:   op_d = OP_JAL;
      OPC_JALR:  op_d = (f3 == 3'b000) ? OP_JALR : '0;
      OPC_BR: begin
        case (f3)
          3'b000:  op_d = OP_BEQ;
          3'b001:  op_d = OP_BNE;
          3'b100:  op_d = OP_BLT;
          3'b101:  op_d = OP_BGE;
          3'b110:  op_d = OP_BLTU;
          3'b111:  op_d = OP_BGEU;
          default: op_d = '0;
        endcase
      end
      OPC_LD: begin
        case (f3)
          3'b000:  op_d = OP_LB;
          3'b001:  op_d = OP_LH;
          3'b010:  op_d = OP_LW;
          3'b100:  op_d = OP_LBU;
          3'b101:  op_d = OP_LHU;
          default: op_d = '0;
        endcase
      end
      OPC_ST: begin
        case (f3)
          3'b000:  op_d = OP_SB;
          3'b001:  op_d = OP_SH;
          3'b010:  op_d = OP_SW;
          default: op_d = '0;
        endcase
      end
      OPC_OPIMM: begin
        case (f3)
          3'b000:  op_d = OP_ADDI;
          3'b010:  op_d = OP_SLTI;
          3'b011:  op_d = OP_SLTIU;
          3'b100:  op_d = OP_XORI;
          3'b110:  op_d = OP_ORI;
          3'b111:  op_d = OP_ANDI;
          3'b001:  op_d = (f7 == 7'b0000000) ? OP_SLLI : '0;
          3'b101:  op_d = (f7 == 7'b0000000) ? OP_SRLI :
                          (f7 == 7'b0100000) ? OP_SRAI : '0;
          default: op_d = '0;
        endcase
      end
      OPC_OP: begin
        case ({f7, f3})
          10'b0000000_000: op_d = OP_ADD;
          10'b0100000_000: op_d = OP_SUB;
          10'b0000000_001: op_d = OP_SLL;
          10'b0000000_010: op_d = OP_SLT;
          10'b0000000_011: op_d = OP_SLTU;
          10'b0000000_100: op_d = OP_XOR;
          10'b0000000_101: op_d = OP_SRL;
          10'b0100000_101: op_d = OP_SRA;
          10'b0000000_110: op_d = OP_OR;
          10'b0000000_111: op_d = OP_AND;
          default:         op_d = '0;
        endcase
      end
      default: op_d = '0;
    endcase

    rs1_d = '0; rs2_d = '0; rd_d = '0; imm_d = '0; has_imm_d = 1'b0;
    if (op_d != '0) begin
      has_imm_d = (opc != OPC_OP);
      case (opc)
        OPC_LUI, OPC_AUIPC: begin
          rd_d  = instruction[11:7];
          imm_d = {instruction[31:12], 12'b0};
        end
        OPC_JAL: begin
          rd_d  = instruction[11:7];
          imm_d = imm_j(instruction);
        end
        OPC_JALR, OPC_LD: begin
          rd_d  = instruction[11:7];
          rs1_d = instruction[19:15];
          imm_d = imm_i(instruction);
        end
        OPC_BR: begin
          rs1_d = instruction[19:15];
          rs2_d = instruction[24:20];
          imm_d = imm_b(instruction);
        end
        OPC_ST: begin
          rs1_d = instruction[19:15];
          rs2_d = instruction[24:20];
          imm_d = imm_s(instruction);
        end
        OPC_OPIMM: begin
          rd_d  = instruction[11:7];
          rs1_d = instruction[19:15];
          imm_d = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, instruction[24:20]}
                                                 : imm_i(instruction);
        end
        OPC_OP: begin
          rd_d  = instruction[11:7];
          rs1_d = instruction[19:15];
          rs2_d = instruction[24:20];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q <= '0; rs1_q <= '0; rs2_q <= '0; rd_q <= '0; imm_q <= '0; has_imm_q <= 1'b0;
    end else begin
      op_q <= op_d; rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d;
      imm_q <= imm_d; has_imm_q <= has_imm_d;
    end
  end

  assign op = op_q;
  assign rs1 = rs1_q;
  assign rs2 = rs2_q;
  assign rd = rd_q;
  assign imm = imm_q;
  assign has_imm = has_imm_q;

`ifdef ALU_AU_DECODER_ILLEGAL_FLAG_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (!rst) illegal_q <= 1'b0;
    else      illegal_q <= (op_d == '0);
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // ALU: loads/stores and unknown codes are not ALU work and produce no result.
  logic signed [31:0] v1_s, v2_s;
  logic [31:0]        sum, alu_res_d, alu_res_q;
  logic [4:0]         shamt;
  logic               alu_vld_d, alu_vld_q, alu_br_q;
  logic [TAG_W-1:0]   alu_tag_q;

  assign v1_s  = alu_value_1;
  assign v2_s  = alu_value_2;
  assign sum   = alu_value_1 + alu_value_2;
  assign shamt = alu_value_2[4:0];

  always_comb begin
    alu_res_d = '0;
    alu_vld_d = 1'b1;
    case (alu_op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_ADD, OP_ADDI: alu_res_d = sum;
      OP_JALR:            alu_res_d = sum & ~32'd1;
      OP_SUB:             alu_res_d = alu_value_1 - alu_value_2;
      OP_SLT, OP_SLTI:    alu_res_d = {31'b0, v1_s < v2_s};
      OP_SLTU, OP_SLTIU:  alu_res_d = {31'b0, alu_value_1 < alu_value_2};
      OP_XOR, OP_XORI:    alu_res_d = alu_value_1 ^ alu_value_2;
      OP_OR, OP_ORI:      alu_res_d = alu_value_1 | alu_value_2;
      OP_AND, OP_ANDI:    alu_res_d = alu_value_1 & alu_value_2;
      OP_SLL, OP_SLLI:    alu_res_d = alu_value_1 << shamt;
      OP_SRL, OP_SRLI:    alu_res_d = alu_value_1 >> shamt;
      OP_SRA, OP_SRAI:    alu_res_d = v1_s >>> shamt;
      OP_BEQ:             alu_res_d = {31'b0, alu_value_1 == alu_value_2};
      OP_BNE:             alu_res_d = {31'b0, alu_value_1 != alu_value_2};
      OP_BLT:             alu_res_d = {31'b0, v1_s < v2_s};
      OP_BGE:             alu_res_d = {31'b0, v1_s >= v2_s};
      OP_BLTU:            alu_res_d = {31'b0, alu_value_1 < alu_value_2};
      OP_BGEU:            alu_res_d = {31'b0, alu_value_1 >= alu_value_2};
      default:            alu_vld_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_res_q <= '0; alu_vld_q <= 1'b0; alu_br_q <= 1'b0; alu_tag_q <= '0;
    end else begin
      alu_res_q <= alu_res_d;
      alu_vld_q <= alu_vld_d;
      alu_br_q  <= alu_vld_d & alu_is_branch_input;
      alu_tag_q <= alu_vld_d ? alu_des_input : '0;
    end
  end

  assign alu_result        = alu_res_q;
  assign alu_valid         = alu_vld_q;
  assign alu_is_branch_out = alu_br_q;
  assign alu_des_rob       = alu_tag_q;
  assign alu_des_rs        = alu_tag_q;

  // Address unit: only memory ops pass through; address wraps modulo 2^32.
  logic              au_mem;
  logic [31:0]       au_addr_q, au_lsv_q;
  logic [TAG_W-1:0]  au_rob_q;
  logic [OP_W-1:0]   au_op_q;
  logic              au_vld_q;

  assign au_mem = (au_op >= OP_LB) && (au_op <= OP_SW);

  always_ff @(posedge clk) begin
    if (!rst || !au_mem) begin
      au_addr_q <= '0; au_lsv_q <= '0; au_rob_q <= '0; au_op_q <= '0; au_vld_q <= 1'b0;
    end else begin
      au_addr_q <= au_value1 + au_imm;
      au_lsv_q  <= au_ls_value;
      au_rob_q  <= au_rob_number_input;
      au_op_q   <= au_op;
      au_vld_q  <= 1'b1;
    end
  end

  assign au_addr            = au_addr_q;
  assign au_ls_value_output = au_lsv_q;
  assign au_rob_number      = au_rob_q;
  assign au_op_out          = au_op_q;
  assign au_valid           = au_vld_q;

endmodule

// File: tb/tb_alu_au_decoder.sv
// Directed bench for alu_au_decoder: decode, ALU, AU, reset flush and illegal flag.
module tb_alu_au_decoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic [5:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        has_imm, illegal;
  logic [31:0] alu_value_1, alu_value_2, alu_result;
  logic [5:0]  alu_op;
  logic [4:0]  alu_des_input, alu_des_rob, alu_des_rs;
  logic        alu_is_branch_input, alu_is_branch_out, alu_valid;
  logic [31:0] au_value1, au_imm, au_ls_value, au_addr, au_ls_value_output;
  logic [5:0]  au_op, au_op_out;
  logic [4:0]  au_rob_number_input, au_rob_number;
  logic        au_valid;

  int n_checks = 0;
  int n_fail   = 0;

  alu_au_decoder #(.OP_W(6), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .instruction(instruction),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .has_imm(has_imm), .illegal(illegal),
    .alu_value_1(alu_value_1), .alu_value_2(alu_value_2), .alu_op(alu_op),
    .alu_des_input(alu_des_input), .alu_is_branch_input(alu_is_branch_input),
    .alu_result(alu_result), .alu_des_rob(alu_des_rob), .alu_des_rs(alu_des_rs),
    .alu_is_branch_out(alu_is_branch_out), .alu_valid(alu_valid),
    .au_value1(au_value1), .au_imm(au_imm), .au_op(au_op),
    .au_rob_number_input(au_rob_number_input), .au_ls_value(au_ls_value),
    .au_addr(au_addr), .au_ls_value_output(au_ls_value_output),
    .au_rob_number(au_rob_number), .au_op_out(au_op_out), .au_valid(au_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instruction = 32'h00500093;
    alu_op = 6'd28; alu_value_1 = 32'd3; alu_value_2 = 32'd4; alu_des_input = 5'd9;
    alu_is_branch_input = 1'b1;
    au_op = 6'd13; au_value1 = 32'h10; au_imm = 32'h4; au_rob_number_input = 5'd2;
    au_ls_value = 32'h55;
    tick(); tick();
    n_checks++;
    if ({op, rs1, rs2, rd, imm, has_imm, illegal} !== 55'd0) begin
      n_fail++; $display("FAIL reset_decode: got op=%0d imm=%h has_imm=%b illegal=%b, want all 0", op, imm, has_imm, illegal);
    end
    n_checks++;
    if ({alu_result, alu_des_rob, alu_des_rs, alu_is_branch_out, alu_valid} !== 44'd0) begin
      n_fail++; $display("FAIL reset_alu: got res=%h tag=%0d/%0d br=%b vld=%b, want all 0", alu_result, alu_des_rob, alu_des_rs, alu_is_branch_out, alu_valid);
    end
    n_checks++;
    if ({au_addr, au_ls_value_output, au_rob_number, au_op_out, au_valid} !== 76'd0) begin
      n_fail++; $display("FAIL reset_au: got addr=%h lsv=%h rob=%0d op=%0d vld=%b, want all 0", au_addr, au_ls_value_output, au_rob_number, au_op_out, au_valid);
    end
    alu_op = 6'd0; au_op = 6'd0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_decode();
    logic [31:0] ins [9]  = '{32'h00500093, 32'hFE209EE3, 32'h123450B7, 32'h002081B3, 32'h0020A423,
                             32'h40335293, 32'hFF9FF0EF, 32'hFFC12203, 32'hFFFFFFFF};
    logic [5:0]  eop [9]  = '{6'd19, 6'd6, 6'd1, 6'd28, 6'd18, 6'd27, 6'd3, 6'd13, 6'd0};
    logic [4:0]  ers1[9]  = '{5'd0, 5'd1, 5'd0, 5'd1, 5'd1, 5'd6, 5'd0, 5'd2, 5'd0};
    logic [4:0]  ers2[9]  = '{5'd0, 5'd2, 5'd0, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [4:0]  erd [9]  = '{5'd1, 5'd0, 5'd1, 5'd3, 5'd0, 5'd5, 5'd1, 5'd4, 5'd0};
    logic [31:0] eimm[9]  = '{32'd5, 32'hFFFFFFFC, 32'h12345000, 32'd0, 32'd8, 32'd3,
                             32'hFFFFFFF8, 32'hFFFFFFFC, 32'd0};
    logic        ehi [9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      instruction = ins[i];
      tick();
      n_checks++;
      if (op !== eop[i]) begin
        n_fail++; $display("FAIL decode_op[%0d]: got %0d want %0d", i, op, eop[i]);
      end
      n_checks++;
      if ({rs1, rs2, rd} !== {ers1[i], ers2[i], erd[i]}) begin
        n_fail++; $display("FAIL decode_regs[%0d]: got rs1=%0d rs2=%0d rd=%0d want %0d %0d %0d", i, rs1, rs2, rd, ers1[i], ers2[i], erd[i]);
      end
      n_checks++;
      if (imm !== eimm[i]) begin
        n_fail++; $display("FAIL decode_imm[%0d]: got %h want %h", i, imm, eimm[i]);
      end
      n_checks++;
      if (has_imm !== ehi[i]) begin
        n_fail++; $display("FAIL decode_has_imm[%0d]: got %b want %b", i, has_imm, ehi[i]);
      end
    end
  endtask

  task automatic test_alu();
    logic [5:0]  aop [13] = '{6'd28, 6'd29, 6'd31, 6'd32, 6'd35, 6'd26, 6'd4, 6'd22, 6'd9, 6'd8, 6'd5, 6'd13, 6'd0};
    logic [31:0] a1  [13] = '{32'd5, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                             32'h1001, 32'hF0F0F0F0, 32'd1, 32'hFFFFFFFF, 32'd42, 32'd1, 32'd1};
    logic [31:0] a2  [13] = '{32'd7, 32'd5, 32'd1, 32'd1, 32'h21, 32'h21, 32'd2, 32'hFFFF0000,
                             32'hFFFFFFFF, 32'd1, 32'd42, 32'd1, 32'd1};
    logic        abr [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    logic [31:0] eres[13] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hC0000000, 32'h40000000,
                             32'h1002, 32'h0F0FF0F0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0};
    logic        evld[13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 13; i++) begin
      alu_op = aop[i]; alu_value_1 = a1[i]; alu_value_2 = a2[i];
      alu_is_branch_input = abr[i]; alu_des_input = 5'(i + 1);
      if (aop[i] == 6'd35) alu_des_input = 5'd7;
      tick();
      n_checks++;
      if ({alu_result, alu_valid} !== {eres[i], evld[i]}) begin
        n_fail++; $display("FAIL alu_result[%0d]: got %h vld=%b want %h vld=%b", i, alu_result, alu_valid, eres[i], evld[i]);
      end
      if (evld[i]) begin
        n_checks++;
        if ({alu_des_rob, alu_des_rs, alu_is_branch_out} !== {alu_des_input, alu_des_input, abr[i]}) begin
          n_fail++; $display("FAIL alu_tag[%0d]: got rob=%0d rs=%0d br=%b want %0d %0d %b", i, alu_des_rob, alu_des_rs, alu_is_branch_out, alu_des_input, alu_des_input, abr[i]);
        end
      end
    end
  endtask

  task automatic test_au();
    logic [5:0]  uop [5] = '{6'd13, 6'd16, 6'd14, 6'd19, 6'd0};
    logic [31:0] ub  [5] = '{32'hFFFFFFFC, 32'h100, 32'h1000, 32'h20, 32'h30};
    logic [31:0] ui  [5] = '{32'd8, 32'hFFFFFFFF, 32'h10, 32'h4, 32'h4};
    logic [31:0] ulsv[5] = '{32'd0, 32'hDEADBEEF, 32'h12345678, 32'h77, 32'h88};
    logic [4:0]  utag[5] = '{5'd3, 5'd5, 5'd6, 5'd8, 5'd9};
    logic [31:0] eadr[5] = '{32'h4, 32'hFF, 32'h1010, 32'd0, 32'd0};
    logic        ev  [5] = '{1, 1, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      au_op = uop[i]; au_value1 = ub[i]; au_imm = ui[i];
      au_ls_value = ulsv[i]; au_rob_number_input = utag[i];
      tick();
      n_checks++;
      if ({au_addr, au_valid} !== {eadr[i], ev[i]}) begin
        n_fail++; $display("FAIL au_addr[%0d]: got %h vld=%b want %h vld=%b", i, au_addr, au_valid, eadr[i], ev[i]);
      end
      n_checks++;
      if ({au_ls_value_output, au_rob_number, au_op_out} !==
          (ev[i] ? {ulsv[i], utag[i], uop[i]} : 43'd0)) begin
        n_fail++; $display("FAIL au_pass[%0d]: got lsv=%h rob=%0d op=%0d", i, au_ls_value_output, au_rob_number, au_op_out);
      end
    end
  endtask

  task automatic test_reset_flush();
    instruction = 32'h00500093;
    alu_op = 6'd28; alu_value_1 = 32'd1; alu_value_2 = 32'd1; alu_des_input = 5'd5;
    alu_is_branch_input = 1'b0;
    au_op = 6'd13; au_value1 = 32'd4; au_imm = 32'd4; au_rob_number_input = 5'd6;
    au_ls_value = 32'h0;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({alu_valid, alu_result, alu_des_rob, au_valid, au_addr, au_rob_number, op, imm} !== 114'd0) begin
      n_fail++; $display("FAIL flush: got alu_vld=%b res=%h au_vld=%b addr=%h op=%0d imm=%h, want all 0", alu_valid, alu_result, au_valid, au_addr, op, imm);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({alu_valid, alu_result, alu_des_rob} !== {1'b1, 32'd2, 5'd5}) begin
      n_fail++; $display("FAIL flush_release_alu: got vld=%b res=%h tag=%0d want 1 00000002 5", alu_valid, alu_result, alu_des_rob);
    end
    n_checks++;
    if ({au_valid, au_addr, au_rob_number, op} !== {1'b1, 32'd8, 5'd6, 6'd19}) begin
      n_fail++; $display("FAIL flush_release_au: got vld=%b addr=%h rob=%0d op=%0d want 1 00000008 6 19", au_valid, au_addr, au_rob_number, op);
    end
    alu_op = 6'd0; au_op = 6'd0;
    tick();
    n_checks++;
    if ({alu_valid, au_valid} !== 2'b00) begin
      n_fail++; $display("FAIL idle_clears_valid: got alu=%b au=%b want 0 0", alu_valid, au_valid);
    end
  endtask

  task automatic test_back_to_back();
    alu_op = 6'd33; alu_value_1 = 32'hAAAA5555; alu_value_2 = 32'hFFFF0000; alu_des_input = 5'd20;
    au_op = 6'd18; au_value1 = 32'h2000; au_imm = 32'hFFFFFFF0; au_rob_number_input = 5'd21;
    tick();
    n_checks++;
    if ({alu_result, au_addr} !== {32'h55555555, 32'h1FF0}) begin
      n_fail++; $display("FAIL b2b_0: got res=%h addr=%h want 55555555 00001ff0", alu_result, au_addr);
    end
    alu_op = 6'd30; alu_value_1 = 32'h1; alu_value_2 = 32'h3F;
    au_op = 6'd0;
    tick();
    n_checks++;
    if ({alu_result, alu_valid, au_valid} !== {32'h80000000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL b2b_1: got res=%h alu_vld=%b au_vld=%b want 80000000 1 0", alu_result, alu_valid, au_valid);
    end
    alu_op = 6'd0;
  endtask

  task automatic test_illegal();
    logic exp_ill;
`ifdef ALU_AU_DECODER_ILLEGAL_FLAG_EN
    exp_ill = 1'b1;
`else
    exp_ill = 1'b0;
`endif
    instruction = 32'hFFFFFFFF;
    tick();
    n_checks++;
    if ({op, illegal} !== {6'd0, exp_ill}) begin
      n_fail++; $display("FAIL illegal_set: got op=%0d illegal=%b want 0 %b", op, illegal, exp_ill);
    end
    instruction = 32'h00500093;
    tick();
    n_checks++;
    if ({op, illegal} !== {6'd19, 1'b0}) begin
      n_fail++; $display("FAIL illegal_clear: got op=%0d illegal=%b want 19 0", op, illegal);
    end
  endtask

  initial begin
    rst = 1'b0; instruction = '0;
    alu_value_1 = '0; alu_value_2 = '0; alu_op = '0; alu_des_input = '0; alu_is_branch_input = 1'b0;
    au_value1 = '0; au_imm = '0; au_op = '0; au_rob_number_input = '0; au_ls_value = '0;
    test_reset();
    test_decode();
    test_alu();
    test_au();
    test_reset_flush();
    test_back_to_back();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
